// File: rtl/hsv_seq_ctrl.sv
// Sequential RGB-to-HSV controller: one pixel in flight, a single shared
// serial restoring divider is used first for S and then for the hue fraction.
//
// state | meaning
// IDLE  | waiting for a pixel, in_ready=1
// LOAD  | select max/min/sector, register delta
// DIV_S | delta*255 / max, one quotient bit per cycle
// DIV_H | 60*|d| / delta, one quotient bit per cycle
// FIX   | apply sector offset and sign, wrap into 0..359
// OUT   | result held until out_ready
module hsv_seq_ctrl #(
    parameter int W        = 10,
    parameter int DIV_ITER = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] R,
    input  logic signed [W-1:0] G,
    input  logic signed [W-1:0] B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        H,
    output logic [W-1:0]        S,
    output logic [W-1:0]        V,
    output logic                busy
);
    localparam int CW = $clog2(DIV_ITER);
    localparam logic [1:0] SEC_R = 2'd0;
    localparam logic [1:0] SEC_G = 2'd1;
    localparam logic [1:0] SEC_B = 2'd2;
    localparam logic signed [W-1:0] C_ZERO = '0;
    localparam logic signed [W-1:0] C_255  = W'(255);

    typedef enum logic [2:0] {IDLE, LOAD, DIV_S, DIV_H, FIX, OUT} state_t;
    state_t state, state_nx;

    logic [7:0]          r_q, g_q, b_q, delta_q, divisor_q, rem_q;
    logic [1:0]          sector_q;
    logic                dneg_q;
    logic [DIV_ITER-1:0] quo_q;
    logic [CW-1:0]       cnt_q;

    logic [7:0]          sel_max, sel_min, sel_delta;
    logic [1:0]          sel_sec;
    logic [8:0]          d;
    logic [7:0]          dmag;
    logic [DIV_ITER-1:0] num_s, num_h, quo_nx;
    logic [8:0]          trial;
    logic                ge;
    logic [7:0]          rem_nx;
    logic                last;
    logic signed [10:0]  h_off, h_q, h_sum;

    function automatic logic [7:0] clamp8(input logic signed [W-1:0] x);
        if (x < C_ZERO)     return 8'd0;
        else if (x > C_255) return 8'd255;
        else                return x[7:0];
    endfunction

    // Strict comparisons give the tie rules: R==G>B -> G, anything with B tied for max -> B.
    always_comb begin
        sel_max = b_q;
        sel_min = r_q;
        sel_sec = SEC_B;
        if (r_q > g_q && r_q > b_q) begin
            sel_max = r_q;
            sel_sec = SEC_R;
            sel_min = (g_q > b_q) ? b_q : g_q;
        end else if (r_q > g_q) begin
            sel_max = b_q;
            sel_sec = SEC_B;
            sel_min = g_q;
        end else if (g_q > b_q) begin
            sel_max = g_q;
            sel_sec = SEC_G;
            sel_min = (r_q > b_q) ? b_q : r_q;
        end
        sel_delta = sel_max - sel_min;
        num_s     = DIV_ITER'(sel_delta) * DIV_ITER'(255);
    end

    always_comb begin
        case (sector_q)
            SEC_R:   d = {1'b0, g_q} - {1'b0, b_q};
            SEC_G:   d = {1'b0, b_q} - {1'b0, r_q};
            default: d = {1'b0, r_q} - {1'b0, g_q};
        endcase
        dmag  = d[8] ? 8'(-d) : d[7:0];
        num_h = DIV_ITER'(dmag) * DIV_ITER'(60);
    end

    // One restoring step: remainder stays below the 8-bit divisor.
    always_comb begin
        trial  = {rem_q, quo_q[DIV_ITER-1]};
        ge     = trial >= {1'b0, divisor_q};
        rem_nx = ge ? 8'(trial - {1'b0, divisor_q}) : trial[7:0];
        quo_nx = {quo_q[DIV_ITER-2:0], ge};
        last   = cnt_q == CW'(DIV_ITER - 1);
    end

    always_comb begin
        case (sector_q)
            SEC_R:   h_off = 11'sd0;
            SEC_G:   h_off = 11'sd120;
            default: h_off = 11'sd240;
        endcase
        h_q   = {4'b0, quo_q[6:0]};
        h_sum = dneg_q ? h_off - h_q : h_off + h_q;
        if (h_sum < 0) h_sum = h_sum + 11'sd360;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = LOAD;
            LOAD:    state_nx = (sel_delta == 8'd0) ? OUT : DIV_S;
            DIV_S:   if (last) state_nx = DIV_H;
            DIV_H:   if (last) state_nx = FIX;
            FIX:     state_nx = OUT;
            OUT:     if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0; g_q <= '0; b_q <= '0;
            delta_q <= '0; divisor_q <= '0; rem_q <= '0;
            sector_q <= '0; dneg_q <= 1'b0; quo_q <= '0; cnt_q <= '0;
            H <= '0; S <= '0; V <= '0; out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    r_q <= clamp8(R);
                    g_q <= clamp8(G);
                    b_q <= clamp8(B);
                end
                LOAD: begin
                    V         <= W'(sel_max);
                    delta_q   <= sel_delta;
                    sector_q  <= sel_sec;
                    divisor_q <= sel_max;
                    rem_q     <= '0;
                    quo_q     <= num_s;
                    cnt_q     <= '0;
                    if (sel_delta == 8'd0) begin
                        H <= '0;
                        S <= '0;
                    end
                end
                DIV_S: if (last) begin
                    S         <= W'(quo_nx[7:0]);
                    divisor_q <= delta_q;
                    rem_q     <= '0;
                    quo_q     <= num_h;
                    dneg_q    <= d[8];
                    cnt_q     <= '0;
                end else begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + 1'b1;
                end
                DIV_H: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= last ? '0 : cnt_q + 1'b1;
                end
                FIX: H <= W'(h_sum);
                OUT: out_valid <= !(out_valid && out_ready);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hsv_seq_ctrl.sv
// Directed bench for hsv_seq_ctrl: a cycle-level reference model built from
// the HSV formulas and latency rules, plus literal per-pixel expectations.
module tb_hsv_seq_ctrl;
    localparam int W        = 10;
    localparam int DIV_ITER = 16;

    logic                clk = 1'b0;
    logic                rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic signed [W-1:0] R, G, B;
    logic [W-1:0]        H, S, V;

    int n_checks = 0;
    int n_errors = 0;

    hsv_seq_ctrl #(.W(W), .DIV_ITER(DIV_ITER)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .R(R), .G(G), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .H(H), .S(S), .V(V), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int x);
        return (x < 0) ? 0 : (x > 255) ? 255 : x;
    endfunction

    function automatic void hsv_model(input int r0, input int g0, input int b0,
                                      output int h, output int s, output int v,
                                      output int lat);
        int r, g, b, mx, mn, delta, dd, off;
        r = clamp(r0); g = clamp(g0); b = clamp(b0);
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        delta = mx - mn;
        v = mx;
        if (delta == 0) begin
            h = 0; s = 0; lat = 2;
            return;
        end
        if (r > g && r > b)       begin dd = g - b; off = 0;   end
        else if (g >= r && g > b) begin dd = b - r; off = 120; end
        else                      begin dd = r - g; off = 240; end
        s = (delta * 255) / mx;
        h = off + (60 * dd) / delta;
        if (h < 0) h += 360;
        lat = 2 * DIV_ITER + 3;
    endfunction

    // Reference model: tracks pixel in flight as a countdown to out_valid.
    int m_busy, m_valid, m_cnt, m_h, m_s, m_v;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                hsv_model(int'(R), int'(G), int'(B), m_h, m_s, m_v, m_cnt);
                m_busy = 1;
            end
        end else if (m_valid) begin
            if (out_ready) begin m_valid = 0; m_busy = 0; end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), 1 - m_busy);
        chk("busy", int'(busy), m_busy);
        chk("out_valid", int'(out_valid), m_valid);
        if (m_valid == 1) begin
            chk("model_H", int'(H), m_h);
            chk("model_S", int'(S), m_s);
            chk("model_V", int'(V), m_v);
        end
    end

    task automatic pin_model(input int r, input int g, input int b,
                             input int eh, input int es, input int ev, input int el);
        int h, s, v, l;
        hsv_model(r, g, b, h, s, v, l);
        chk("pin_H", h, eh);
        chk("pin_S", s, es);
        chk("pin_V", v, ev);
        chk("pin_lat", l, el);
    endtask

    task automatic run_pixel(input int r, input int g, input int b,
                             input int eh, input int es, input int ev,
                             input int elat, input int hold);
        int n, h0, s0, v0;
        @(posedge clk); #2;
        chk("pre_in_ready", int'(in_ready), 1);
        R = W'(r); G = W'(g); B = W'(b); in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        R = W'(77); G = W'(-3); B = W'(400);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("latency", n, elat);
        chk("H", int'(H), eh);
        chk("S", int'(S), es);
        chk("V", int'(V), ev);
        h0 = int'(H); s0 = int'(S); v0 = int'(V);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #2;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_H", int'(H), h0);
            chk("hold_S", int'(S), s0);
            chk("hold_V", int'(V), v0);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        R = '0; G = '0; B = '0;
        #1 rst_n = 1'b0;
        #10;
        chk("rst_H", int'(H), 0);
        chk("rst_S", int'(S), 0);
        chk("rst_V", int'(V), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #2 rst_n = 1'b1;

        pin_model(255, 0, 128, 330, 255, 255, 35);
        pin_model(200, 200, 50, 60, 191, 200, 35);
        pin_model(-5, 300, 0, 120, 255, 255, 35);
        pin_model(100, 100, 100, 0, 0, 100, 2);

        run_pixel(255, 0, 0,     0, 255, 255, 35, 0);
        run_pixel(255, 0, 128, 330, 255, 255, 35, 0);
        run_pixel(0, 128, 255, 210, 255, 255, 35, 0);
        run_pixel(200, 200, 50, 60, 191, 200, 35, 0);
        run_pixel(0, 255, 0,   120, 255, 255, 35, 0);
        run_pixel(100, 100, 100, 0,   0, 100,  2, 0);
        run_pixel(10, 20, 30,  210, 170,  30, 35, 0);
        run_pixel(-5, 300, 0,  120, 255, 255, 35, 5);

        // Abort a pixel while it is in the hue divide.
        @(posedge clk); #2;
        R = W'(255); G = W'(0); B = W'(128); in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_H", int'(H), 0);
        chk("abort_S", int'(S), 0);
        chk("abort_V", int'(V), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        run_pixel(255, 0, 0, 0, 255, 255, 35, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
